usb_tx_packetizer: RTL and testbench

Parametrised USB full-speed transmit engine that serialises a complete packet onto dp/dm. Packets are SYNC, PID, optional DATA payload, CRC16 and EOP, sent with NRZI encoding and bit stuffing. Adds DATA1, a configurable bit period, a payload-length limit, explicit error reporting and a done pulse. It sits between the endpoint FIFO (byte-fetch handshake) and the USB pad drivers, under the protocol controller.

---
 rtl/usb_pkg.sv | 47 ++++
 rtl/usb_tx_nrzi_stuffer.sv | 58 +++++
 rtl/usb_tx_packetizer.sv | 180 ++++++++++++++++++
 tb/tb_usb_tx_packetizer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB transmit definitions: packet kinds, PID nibbles, SYNC byte, CRC16 constants
// and the dp/dm line-state encodings.
package usb_pkg;

   typedef enum logic [2:0] {
      PKT_DATA0 = 3'd0,
      PKT_DATA1 = 3'd1,
      PKT_ACK   = 3'd2,
      PKT_NAK   = 3'd3,
      PKT_STALL = 3'd4
   } tx_packet_t;

   localparam logic [3:0] PID_DATA0 = 4'h3;
   localparam logic [3:0] PID_DATA1 = 4'hB;
   localparam logic [3:0] PID_ACK   = 4'h2;
   localparam logic [3:0] PID_NAK   = 4'hA;
   localparam logic [3:0] PID_STALL = 4'hE;

   localparam logic [7:0]  SYNC_BYTE  = 8'h80;
   localparam logic [15:0] CRC16_POLY = 16'h8005;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   // {dp, dm}
   localparam logic [1:0] J   = 2'b10;
   localparam logic [1:0] K   = 2'b01;
   localparam logic [1:0] SE0 = 2'b00;

   function automatic logic [15:0] bitrev16(input logic [15:0] v);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) r[i] = v[15-i];
      return r;
   endfunction

   function automatic logic [7:0] pid_byte(input logic [2:0] pkt);
      logic [3:0] p;
      case (pkt)
         PKT_DATA0: p = PID_DATA0;
         PKT_DATA1: p = PID_DATA1;
         PKT_ACK:   p = PID_ACK;
         PKT_NAK:   p = PID_NAK;
         default:   p = PID_STALL;
      endcase
      return {~p, p};
   endfunction

endpackage

// File: rtl/usb_tx_nrzi_stuffer.sv
// Line encoder: NRZI-encodes one bit per strobe, inserts stuffed zeros after six ones,
// and can override the line with SE0 or J for the end-of-packet.
module usb_tx_nrzi_stuffer
   import usb_pkg::*;
(
   input  logic clk,
   input  logic n_rst,
   input  logic i_bit_vld,
   input  logic i_bit,
   input  logic i_clr,
   input  logic i_stuff_en,
   input  logic i_force_se0,
   input  logic i_force_j,
   output logic o_stall,
   output logic o_dp,
   output logic o_dm
);

   logic [2:0] r_ones;
   logic       r_lvl;
   logic [1:0] r_line;
   logic       w_lvl_base;
   logic       w_lvl_nxt;
   logic [2:0] w_ones_base;

   // A start restarts from idle J with an empty ones run.
   assign w_lvl_base  = i_clr ? 1'b1 : r_lvl;
   assign w_ones_base = i_clr ? 3'd0 : r_ones;
   assign w_lvl_nxt   = i_bit ? w_lvl_base : ~w_lvl_base;
   assign o_stall     = i_stuff_en && (r_ones == 3'd6);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_ones <= '0;
         r_lvl  <= 1'b1;
         r_line <= J;
      end else if (i_bit_vld) begin
         if (o_stall) begin
            r_lvl  <= ~r_lvl;
            r_ones <= '0;
            r_line <= r_lvl ? K : J;
         end else if (i_force_se0) begin
            r_line <= SE0;
         end else if (i_force_j) begin
            r_lvl  <= 1'b1;
            r_line <= J;
         end else begin
            r_lvl  <= w_lvl_nxt;
            r_line <= w_lvl_nxt ? J : K;
            r_ones <= i_bit ? w_ones_base + 3'd1 : 3'd0;
         end
      end
   end

   assign o_dp = r_line[1];
   assign o_dm = r_line[0];

endmodule

// File: rtl/usb_tx_packetizer.sv
// USB full-speed transmit engine: SYNC, PID, optional payload, CRC16 and EOP onto dp/dm,
// fetching payload bytes from the endpoint FIFO one bit time ahead of use.
module usb_tx_packetizer
   import usb_pkg::*;
#(
   parameter int CLKS_PER_BIT = 8,
   parameter int MAX_PAYLOAD  = 64,
   parameter int OCC_W        = 7
)(
   input  logic             clk,
   input  logic             n_rst,
   input  logic             tx_start,
   input  logic [2:0]       tx_packet,
   input  logic [OCC_W-1:0] buffer_occupancy,
   input  logic [7:0]       tx_packet_data,
   output logic             get_tx_packet_data,
   output logic             dp,
   output logic             dm,
   output logic             tx_transfer_active,
   output logic             tx_done,
   output logic             tx_error
);

   localparam int          TMR_W        = $clog2(CLKS_PER_BIT);
   localparam logic [15:0] CRC_POLY_REF = bitrev16(CRC16_POLY);

   typedef enum logic [2:0] {
      S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_EOP
   } tx_state_t;

   tx_state_t        r_state, w_state_nxt;
   logic [TMR_W-1:0] r_tmr;
   logic [2:0]       r_bitcnt;
   logic [7:0]       r_shift;
   logic [OCC_W-1:0] r_len;
   logic [15:0]      r_crc;
   logic             r_is_data, r_get, r_cap, r_err;

   logic w_bnd, w_is_data_req, w_bad, w_stall, w_stuff_en;
   logic w_accept, w_reject, w_step, w_fetch;
   logic w_bit_vld, w_bit, w_clr, w_force_se0, w_force_j, w_crc_fb;

   assign w_bnd         = (r_state != S_IDLE) && (r_tmr == TMR_W'(CLKS_PER_BIT-1));
   assign w_is_data_req = (tx_packet == PKT_DATA0) || (tx_packet == PKT_DATA1);
   assign w_bad         = (tx_packet > 3'd4) ||
                          (w_is_data_req && (buffer_occupancy > OCC_W'(MAX_PAYLOAD)));
   // The first EOP slot still admits a stuffed bit owed by the last CRC bit.
   assign w_stuff_en    = (r_state inside {S_PID, S_DATA, S_CRC_LO, S_CRC_HI}) ||
                          ((r_state == S_EOP) && (r_bitcnt == 3'd0));
   assign w_crc_fb      = r_crc[0] ^ r_shift[0];

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // r_bitcnt indexes the next bit to emit; emission happens at each bit boundary.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_reject    = 1'b0;
      w_step      = 1'b0;
      w_fetch     = 1'b0;
      w_bit_vld   = 1'b0;
      w_bit       = 1'b1;
      w_clr       = 1'b0;
      w_force_se0 = 1'b0;
      w_force_j   = 1'b0;
      if (r_state == S_IDLE) begin
         if (tx_start) begin
            if (w_bad) begin
               w_reject = 1'b1;
            end else begin
               w_accept    = 1'b1;
               w_state_nxt = S_SYNC;
               w_bit_vld   = 1'b1;
               w_bit       = SYNC_BYTE[0];
               w_clr       = 1'b1;
            end
         end
      end else if (w_bnd) begin
         w_bit_vld = 1'b1;
         if (!w_stall) begin
            w_step = 1'b1;
            case (r_state)
               S_SYNC:             w_bit = SYNC_BYTE[r_bitcnt];
               S_PID, S_DATA:      w_bit = r_shift[0];
               S_CRC_LO, S_CRC_HI: w_bit = ~r_crc[0];
               S_EOP: begin
                  w_force_se0 = (r_bitcnt < 3'd2);
                  w_force_j   = (r_bitcnt == 3'd2);
                  w_bit_vld   = (r_bitcnt != 3'd3);
                  if (r_bitcnt == 3'd3) w_state_nxt = S_IDLE;
               end
               default: ;
            endcase
            if (r_bitcnt == 3'd7) begin
               case (r_state)
                  S_SYNC: w_state_nxt = S_PID;
                  S_PID, S_DATA: begin
                     if (r_is_data && (r_len != '0)) begin
                        w_fetch     = 1'b1;
                        w_state_nxt = S_DATA;
                     end else if (r_is_data) begin
                        w_state_nxt = S_CRC_LO;
                     end else begin
                        w_state_nxt = S_EOP;
                     end
                  end
                  S_CRC_LO: w_state_nxt = S_CRC_HI;
                  S_CRC_HI: w_state_nxt = S_EOP;
                  default: ;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_tmr     <= '0;
         r_bitcnt  <= '0;
         r_shift   <= '0;
         r_len     <= '0;
         r_crc     <= '0;
         r_is_data <= 1'b0;
         r_get     <= 1'b0;
         r_cap     <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_err <= w_reject;
         r_get <= w_fetch;
         r_cap <= r_get;
         if ((r_state == S_IDLE) || w_bnd) r_tmr <= '0;
         else                              r_tmr <= r_tmr + 1'b1;
         if (w_fetch) r_len <= r_len - 1'b1;
         if (w_accept) begin
            r_bitcnt  <= 3'd1;
            r_shift   <= pid_byte(tx_packet);
            r_crc     <= CRC16_INIT;
            r_is_data <= w_is_data_req;
            r_len     <= w_is_data_req ? buffer_occupancy : '0;
         end else if (r_cap) begin
            r_shift <= tx_packet_data;
         end else if (w_step) begin
            r_bitcnt <= r_bitcnt + 3'd1;
            case (r_state)
               S_PID: r_shift <= r_shift >> 1;
               S_DATA: begin
                  r_shift <= r_shift >> 1;
                  r_crc   <= (r_crc >> 1) ^ (w_crc_fb ? CRC_POLY_REF : 16'h0000);
               end
               S_CRC_LO, S_CRC_HI: r_crc <= r_crc >> 1;
               default: ;
            endcase
         end
      end
   end

   usb_tx_nrzi_stuffer u_nrzi (
      .clk         (clk),
      .n_rst       (n_rst),
      .i_bit_vld   (w_bit_vld),
      .i_bit       (w_bit),
      .i_clr       (w_clr),
      .i_stuff_en  (w_stuff_en),
      .i_force_se0 (w_force_se0),
      .i_force_j   (w_force_j),
      .o_stall     (w_stall),
      .o_dp        (dp),
      .o_dm        (dm)
   );

   assign get_tx_packet_data = r_get;
   assign tx_error           = r_err;
   assign tx_transfer_active = (r_state != S_IDLE);
   assign tx_done            = (r_state == S_EOP) && (r_bitcnt == 3'd3) &&
                               (r_tmr == TMR_W'(CLKS_PER_BIT-1));

endmodule

// File: tb/tb_usb_tx_packetizer.sv
// Randomised bench for usb_tx_packetizer: decodes dp/dm per bit time and compares against
// a line-symbol model built from the packet rules.
module tb_usb_tx_packetizer;

   localparam int CPB  = 8;
   localparam int MAXP = 64;
   localparam int OCCW = 7;
   localparam logic [1:0] SJ = 2'b10, SK = 2'b01, SZ = 2'b00;

   logic            clk = 1'b0;
   logic            n_rst = 1'b0;
   logic            tx_start = 1'b0;
   logic [2:0]      tx_packet = '0;
   logic [OCCW-1:0] buffer_occupancy = '0;
   logic [7:0]      tx_packet_data = '0;
   logic            get, dp, dm, act, done, err;

   int checks = 0;
   int errors = 0;
   byte unsigned fifo[$];
   int fidx = 0;
   logic [1:0] exp_q[$];
   logic [1:0] obs_q[$];

   always #5 clk = ~clk;

   usb_tx_packetizer #(.CLKS_PER_BIT(CPB), .MAX_PAYLOAD(MAXP), .OCC_W(OCCW)) dut (
      .clk                (clk),
      .n_rst              (n_rst),
      .tx_start           (tx_start),
      .tx_packet          (tx_packet),
      .buffer_occupancy   (buffer_occupancy),
      .tx_packet_data     (tx_packet_data),
      .get_tx_packet_data (get),
      .dp                 (dp),
      .dm                 (dm),
      .tx_transfer_active (act),
      .tx_done            (done),
      .tx_error           (err)
   );

   // Endpoint FIFO: presents the next byte after each pop strobe.
   always @(negedge clk) begin
      if (get === 1'b1) begin
         tx_packet_data = (fidx < fifo.size()) ? fifo[fidx] : 8'h00;
         fidx++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Expected line symbols, one per bit time, from first SYNC bit to the final J.
   task automatic build_exp(input int pt);
      logic [7:0]  pidb, by;
      logic [15:0] c;
      logic        b, fb, lvl;
      int          ones;
      logic        bits[$];
      case (pt)
         0: pidb = 8'hC3;
         1: pidb = 8'h4B;
         2: pidb = 8'hD2;
         3: pidb = 8'h5A;
         default: pidb = 8'h1E;
      endcase
      exp_q.delete();
      for (int i = 0; i < 8; i++) bits.push_back(pidb[i]);
      if (pt < 2) begin
         c = 16'hFFFF;
         foreach (fifo[k]) begin
            by = fifo[k];
            for (int i = 0; i < 8; i++) begin
               b  = by[i];
               bits.push_back(b);
               fb = b ^ c[15];
               c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
            end
         end
         for (int i = 15; i >= 0; i--) bits.push_back(~c[i]);
      end
      lvl = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i != 7) lvl = ~lvl;
         exp_q.push_back(lvl ? SJ : SK);
      end
      ones = 0;
      foreach (bits[i]) begin
         if (!bits[i]) lvl = ~lvl;
         exp_q.push_back(lvl ? SJ : SK);
         ones = bits[i] ? ones + 1 : 0;
         if (ones == 6) begin
            lvl = ~lvl;
            exp_q.push_back(lvl ? SJ : SK);
            ones = 0;
         end
      end
      exp_q.push_back(SZ);
      exp_q.push_back(SZ);
      exp_q.push_back(SJ);
   endtask

   // mode: 0 random bytes, 1 all 0xFF, 2 incrementing. repulse_at < 0 means no second start.
   task automatic send(input int pt, input int len, input int mode, input int repulse_at);
      int cyc, gets, dones, done_cyc, glitch, errs, first_bad;
      logic [1:0] sym;
      fifo.delete();
      fidx = 0;
      if (pt < 2)
         for (int k = 0; k < len; k++)
            fifo.push_back((mode == 0) ? 8'($urandom) : (mode == 1) ? 8'hFF : 8'(k));
      build_exp(pt);
      @(negedge clk);
      tx_packet = 3'(pt);
      buffer_occupancy = OCCW'(len);
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      obs_q.delete();
      cyc = 0; gets = 0; dones = 0; done_cyc = -1; glitch = 0; errs = 0;
      while (act === 1'b1 && cyc < 8000) begin
         sym = {dp, dm};
         if (cyc % CPB == 0) obs_q.push_back(sym);
         else if (sym !== obs_q[$]) glitch++;
         if (get === 1'b1) gets++;
         if (done === 1'b1) begin dones++; done_cyc = cyc; end
         if (err === 1'b1) errs++;
         if (cyc == repulse_at) begin
            tx_start = 1'b1;
            tx_packet = 3'($urandom_range(7));
            buffer_occupancy = OCCW'($urandom_range(127));
         end else begin
            tx_start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      tx_start = 1'b0;
      chk("active_cycles", cyc, exp_q.size() * CPB);
      chk("bit_count", obs_q.size(), exp_q.size());
      first_bad = -1;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         if (obs_q[i] !== exp_q[i]) begin first_bad = i; break; end
      chk("line_first_bad_bit", first_bad, 32'hFFFF_FFFF);
      chk("mid_bit_change", glitch, 0);
      chk("get_strobes", gets, (pt < 2) ? len : 0);
      chk("done_pulses", dones, 1);
      chk("done_on_last", done_cyc, cyc - 1);
      chk("error_while_busy", errs, 0);
      chk("rest_line_J", {dp, dm}, SJ);
      chk("done_low_after", done, 1'b0);
   endtask

   task automatic send_bad(input int pt, input int occ);
      @(negedge clk);
      tx_packet = 3'(pt);
      buffer_occupancy = OCCW'(occ);
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      chk("reject_err_pulse", err, 1'b1);
      chk("reject_active", act, 1'b0);
      chk("reject_line", {dp, dm}, SJ);
      @(negedge clk);
      chk("reject_err_once", err, 1'b0);
      chk("reject_active2", act, 1'b0);
      chk("reject_get", get, 1'b0);
   endtask

   initial begin
      int pt, len;
      repeat (3) @(negedge clk);
      chk("rst_dp", dp, 1'b1);
      chk("rst_dm", dm, 1'b0);
      chk("rst_active", act, 1'b0);
      chk("rst_get", get, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_error", err, 1'b0);
      n_rst = 1'b1;
      repeat (2) @(negedge clk);

      send(2, 0, 0, -1);
      send(0, 0, 0, -1);
      send(1, 1, 1, -1);
      send_bad(6, 0);
      send_bad(0, 65);
      send_bad($urandom_range(7, 5), $urandom_range(64));
      send_bad(1, $urandom_range(127, 65));
      send(0, 64, 2, 500);
      send(1, 64, 1, 40);
      for (int n = 0; n < 12; n++) begin
         pt  = $urandom_range(4);
         len = $urandom_range(MAXP);
         send(pt, len, $urandom_range(2), (n % 3 == 0) ? $urandom_range(400) : -1);
      end

      // Reset in the middle of the payload.
      fifo.delete();
      fidx = 0;
      for (int k = 0; k < 10; k++) fifo.push_back(8'($urandom));
      @(negedge clk);
      tx_packet = 3'd0;
      buffer_occupancy = OCCW'(10);
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      repeat (30 * CPB) @(negedge clk);
      chk("pre_reset_active", act, 1'b1);
      #2 n_rst = 1'b0;
      #1;
      chk("abort_dp", dp, 1'b1);
      chk("abort_dm", dm, 1'b0);
      chk("abort_get", get, 1'b0);
      chk("abort_active", act, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_error", err, 1'b0);
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      send(2, 0, 0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
